heat_stencil_jacobi: RTL and testbench

Parametrised 5-point-stencil heat-diffusion engine; successor to the fixed 8x8/4-bit in-place solver. It holds two grid banks and runs true Jacobi sweeps: it reads the source bank and writes the destination bank, one cell per cycle. It supports iteration limits, convergence detection, and a valid/ready host command port. It sits behind the chip-level mode decoder, which drives its command and config ports from ui_in/uio_in.

---
 rtl/heat_stencil_jacobi.sv | 232 +++++++++++++++++++++++
 tb/tb_heat_stencil_jacobi.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/heat_stencil_jacobi.sv
// Two-bank Jacobi 5-point heat-diffusion engine: sweeps src->dst one cell per cycle,
// then swaps banks and checks for iteration limit or convergence.
module heat_stencil_jacobi #(
  parameter int GRID_W  = 8,
  parameter int GRID_H  = 8,
  parameter int TW      = 4,
  parameter int ALPHA_W = 3,
  localparam int AW     = $clog2(GRID_W * GRID_H)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [AW-1:0]      cmd_addr,
  input  logic [TW-1:0]      cmd_data,
  output logic               rd_valid,
  output logic [TW-1:0]      rd_data,
  input  logic [ALPHA_W-1:0] alpha,
  input  logic [TW-1:0]      bnd_temp,
  input  logic               bnd_neumann,
  input  logic [15:0]        max_iters,
  input  logic [TW-1:0]      conv_thresh,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [15:0]        iter_count,
  output logic [TW-1:0]      max_temp,
  output logic [AW-1:0]      max_cell
);
  localparam int N  = GRID_W * GRID_H;
  localparam int SW = TW + 2;
  localparam int PW = TW + ALPHA_W + 2;
  localparam logic signed [PW-1:0] TMAX = PW'((1 << TW) - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, SWAP = 2'd2, DONE = 2'd3} state_t;
  state_t state, state_nxt;

  logic [TW-1:0]      bank_a [N];
  logic [TW-1:0]      bank_b [N];
  logic               src_sel;
  logic [AW-1:0]      idx, cx, cy;
  logic [ALPHA_W-1:0] alpha_q;
  logic [TW-1:0]      bnd_q, thresh_q;
  logic               neu_q;
  logic [15:0]        iters_q, iter_inc;
  logic [TW-1:0]      run_max, sweep_dmax;
  logic [AW-1:0]      run_cell;
  logic               accept, wr_acc, rd_acc, start_acc, abort, swap_go;
  logic               last_cell, conv_hit, lim_hit;

  function automatic logic [TW-1:0] sat_temp(input logic signed [PW-1:0] v);
    if (v[PW-1]) return '0;
    if (v > TMAX) return '1;
    return v[TW-1:0];
  endfunction

  function automatic logic [TW-1:0] abs_diff(input logic [TW-1:0] a, input logic [TW-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  always_comb begin
    accept    = cmd_valid && cmd_ready;
    wr_acc    = accept && (cmd_op == 2'b00);
    rd_acc    = accept && (cmd_op == 2'b01);
    start_acc = accept && (cmd_op == 2'b10);
    abort     = accept && (cmd_op == 2'b11) && busy;
    swap_go   = (state == SWAP) && !abort;
    last_cell = (idx == AW'(N - 1));
    iter_inc  = (iter_count == 16'hFFFF) ? iter_count : iter_count + 16'd1;
    conv_hit  = (sweep_dmax <= thresh_q);
    lim_hit   = (iters_q != 16'd0) && (iter_inc == iters_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_acc) state_nxt = SWEEP;
      SWEEP: begin
        if (abort)          state_nxt = IDLE;
        else if (last_cell) state_nxt = SWAP;
      end
      SWAP: begin
        if (abort)                    state_nxt = IDLE;
        else if (conv_hit || lim_hit) state_nxt = DONE;
        else                          state_nxt = SWEEP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == SWEEP) || (state == SWAP);
    cmd_ready = rst_n && (!busy || (cmd_op == 2'b11));
  end

  // Stencil datapath: neighbour indices clamp at the grid edge (Neumann mirror)
  logic [AW-1:0]        a_l, a_r, a_u, a_d;
  logic [TW-1:0]        t_c, t_l, t_r, t_u, t_d, t_new, d_abs, avg;
  logic [SW-1:0]        sum;
  logic signed [TW:0]   lap;
  logic signed [PW-1:0] lap_x, alpha_x, prod, step, raw;
  logic                 on_edge;

  always_comb begin
    a_l     = (cx == '0)               ? idx : idx - AW'(1);
    a_r     = (cx == AW'(GRID_W - 1))  ? idx : idx + AW'(1);
    a_u     = (cy == '0)               ? idx : idx - AW'(GRID_W);
    a_d     = (cy == AW'(GRID_H - 1))  ? idx : idx + AW'(GRID_W);
    t_c     = src_sel ? bank_b[idx] : bank_a[idx];
    t_l     = src_sel ? bank_b[a_l] : bank_a[a_l];
    t_r     = src_sel ? bank_b[a_r] : bank_a[a_r];
    t_u     = src_sel ? bank_b[a_u] : bank_a[a_u];
    t_d     = src_sel ? bank_b[a_d] : bank_a[a_d];
    sum     = SW'(t_l) + SW'(t_r) + SW'(t_u) + SW'(t_d);
    avg     = TW'(sum >> 2);
    lap     = $signed({1'b0, avg}) - $signed({1'b0, t_c});
    lap_x   = {{(PW - TW - 1){lap[TW]}}, lap};
    alpha_x = $signed({{(PW - ALPHA_W){1'b0}}, alpha_q});
    prod    = lap_x * alpha_x;
    step    = prod >>> ALPHA_W;
    raw     = $signed({{(PW - TW){1'b0}}, t_c}) + step;
    on_edge = (cx == '0) || (cx == AW'(GRID_W - 1)) || (cy == '0) || (cy == AW'(GRID_H - 1));
    t_new   = (on_edge && !neu_q) ? bnd_q : sat_temp(raw);
    d_abs   = abs_diff(t_new, t_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        bank_a[i] <= '0;
        bank_b[i] <= '0;
      end
    end else begin
      if (wr_acc) begin
        if (src_sel) bank_b[cmd_addr] <= cmd_data;
        else         bank_a[cmd_addr] <= cmd_data;
      end
      if (state == SWEEP) begin
        if (src_sel) bank_a[idx] <= t_new;
        else         bank_b[idx] <= t_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max    <= '0;
      run_cell   <= '0;
      sweep_dmax <= '0;
    end else if (state == SWEEP) begin
      // Cell 0 restarts the per-sweep statistics; strict compare keeps the lowest index
      if (idx == '0 || t_new > run_max) begin
        run_max  <= t_new;
        run_cell <= idx;
      end
      if (idx == '0 || d_abs > sweep_dmax) sweep_dmax <= d_abs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_sel    <= 1'b0;
      idx        <= '0;
      cx         <= '0;
      cy         <= '0;
      alpha_q    <= '0;
      bnd_q      <= '0;
      thresh_q   <= '0;
      neu_q      <= 1'b0;
      iters_q    <= '0;
      done       <= 1'b0;
      converged  <= 1'b0;
      iter_count <= '0;
      max_temp   <= '0;
      max_cell   <= '0;
    end else begin
      if (start_acc) begin
        alpha_q    <= alpha;
        bnd_q      <= bnd_temp;
        thresh_q   <= conv_thresh;
        neu_q      <= bnd_neumann;
        iters_q    <= max_iters;
        done       <= 1'b0;
        converged  <= 1'b0;
        iter_count <= '0;
        idx        <= '0;
        cx         <= '0;
        cy         <= '0;
      end
      if (state == SWEEP) begin
        if (last_cell) begin
          idx <= '0;
          cx  <= '0;
          cy  <= '0;
        end else begin
          idx <= idx + AW'(1);
          if (cx == AW'(GRID_W - 1)) begin
            cx <= '0;
            cy <= cy + AW'(1);
          end else begin
            cx <= cx + AW'(1);
          end
        end
      end
      if (swap_go) begin
        src_sel    <= ~src_sel;
        iter_count <= iter_inc;
        max_temp   <= run_max;
        max_cell   <= run_cell;
        if (conv_hit)            converged <= 1'b1;
        if (conv_hit || lim_hit) done      <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= src_sel ? bank_b[cmd_addr] : bank_a[cmd_addr];
    end
  end

endmodule

// File: tb/tb_heat_stencil_jacobi.sv
// Randomised bench for heat_stencil_jacobi against a plain-arithmetic Jacobi grid model.
`timescale 1ns/1ps
module tb_heat_stencil_jacobi;
  localparam int GW = 8, GH = 8, TW = 4, AL = 3;
  localparam int N = GW * GH, AW = $clog2(N);

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [TW-1:0] cmd_data = '0;
  logic          rd_valid;
  logic [TW-1:0] rd_data;
  logic [AL-1:0] alpha = '0;
  logic [TW-1:0] bnd_temp = '0, conv_thresh = '0;
  logic          bnd_neumann = 1'b0;
  logic [15:0]   max_iters = '0;
  logic          busy, done, converged;
  logic [15:0]   iter_count;
  logic [TW-1:0] max_temp;
  logic [AW-1:0] max_cell;

  int n_tests = 0, n_fail = 0;
  int g[N];

  always #5 clk = ~clk;

  heat_stencil_jacobi #(.GRID_W(GW), .GRID_H(GH), .TW(TW), .ALPHA_W(AL)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .alpha(alpha), .bnd_temp(bnd_temp),
    .bnd_neumann(bnd_neumann), .max_iters(max_iters), .conv_thresh(conv_thresh),
    .busy(busy), .done(done), .converged(converged), .iter_count(iter_count),
    .max_temp(max_temp), .max_cell(max_cell)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int fdiv(input int p, input int d);
    int q;
    q = p / d;
    if ((p % d) != 0 && p < 0) q--;
    return q;
  endfunction

  // Whole-run Jacobi model on g[]: returns sweeps, convergence flag, last-sweep max and its cell
  task automatic model_run(output int iters, output bit conv, output int mt, output int mc);
    int ng[N];
    int maxd, c, nv, l, r, u, d, i, a, b, mi, th;
    bit neu, fin;
    a = int'(alpha); b = int'(bnd_temp); neu = bnd_neumann;
    mi = int'(max_iters); th = int'(conv_thresh);
    iters = 0; conv = 0; mt = 0; mc = 0; fin = 0;
    while (!fin) begin
      maxd = 0; mt = -1; mc = 0;
      for (int y = 0; y < GH; y++) begin
        for (int x = 0; x < GW; x++) begin
          i = y * GW + x;
          c = g[i];
          if (!neu && (x == 0 || x == GW - 1 || y == 0 || y == GH - 1)) begin
            nv = b;
          end else begin
            l = g[y * GW + ((x > 0) ? x - 1 : x)];
            r = g[y * GW + ((x < GW - 1) ? x + 1 : x)];
            u = g[((y > 0) ? y - 1 : y) * GW + x];
            d = g[((y < GH - 1) ? y + 1 : y) * GW + x];
            nv = c + fdiv(((l + r + u + d) / 4 - c) * a, 1 << AL);
            if (nv < 0) nv = 0;
            if (nv > (1 << TW) - 1) nv = (1 << TW) - 1;
          end
          ng[i] = nv;
          if (((nv > c) ? nv - c : c - nv) > maxd) maxd = (nv > c) ? nv - c : c - nv;
          if (nv > mt) begin mt = nv; mc = i; end
        end
      end
      g = ng;
      if (iters < 65535) iters++;
      if (maxd <= th) begin conv = 1; fin = 1; end
      else if (mi != 0 && iters == mi) fin = 1;
      else if (iters > 500) fin = 1;
    end
  endtask

  task automatic send(input logic [1:0] op, input int addr, input int data);
    int w;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = AW'(addr); cmd_data = TW'(data);
    #1; w = 0;
    while (!cmd_ready && w < 300) begin @(negedge clk); #1; w++; end
    if (w >= 300) check_eq("cmd_accept_timeout", int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic set_cell(input int a, input int v);
    send(2'b00, a, v);
    g[a] = v;
  endtask

  task automatic rd_cell(input string tag, input int a, input int exp);
    send(2'b01, a, 0);
    check_eq({tag, "_rdv"}, int'(rd_valid), 1);
    check_eq(tag, int'(rd_data), exp);
  endtask

  // Back-to-back reads of every cell, each result checked one cycle after its accept
  task automatic dump_check(input string tag);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      if (k > 0) check_eq($sformatf("%s_c%0d", tag, k - 1), int'(rd_data), g[k - 1]);
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = AW'(k);
    end
    @(negedge clk);
    check_eq($sformatf("%s_c%0d", tag, N - 1), int'(rd_data), g[N - 1]);
    check_eq({tag, "_rdv_hi"}, int'(rd_valid), 1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_rdv_lo"}, int'(rd_valid), 0);
  endtask

  task automatic run_and_check(input string tag);
    int ei, emt, emc, cyc, budget;
    bit ec;
    model_run(ei, ec, emt, emc);
    send(2'b10, 0, 0);
    check_eq({tag, "_busy"}, int'(busy), 1);
    check_eq({tag, "_done_clr"}, int'(done), 0);
    budget = ei * (N + 1) + 20;
    cyc = 0;
    while (!done && cyc < budget) begin @(posedge clk); #1; cyc++; end
    check_eq({tag, "_cycles"}, cyc, ei * (N + 1));
    check_eq({tag, "_iters"}, int'(iter_count), ei);
    check_eq({tag, "_conv"}, int'(converged), int'(ec));
    check_eq({tag, "_maxt"}, int'(max_temp), emt);
    check_eq({tag, "_maxc"}, int'(max_cell), emc);
    check_eq({tag, "_idle"}, int'(busy), 0);
    dump_check(tag);
  endtask

  task automatic clear_grid();
    for (int k = 0; k < N; k++) if (g[k] != 0) set_cell(k, 0);
  endtask

  initial begin
    int rdy;
    for (int k = 0; k < N; k++) g[k] = 0;

    repeat (3) @(negedge clk);
    check_eq("rst_ready", int'(cmd_ready), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_iters", int'(iter_count), 0);
    check_eq("rst_rdv", int'(rd_valid), 0);
    rst_n = 1'b1;
    #1;
    check_eq("rel_ready", int'(cmd_ready), 1);
    dump_check("rst");

    // Single hot cell, one Dirichlet sweep
    set_cell(27, 15);
    alpha = 3'd2; bnd_temp = '0; bnd_neumann = 1'b0; max_iters = 16'd1; conv_thresh = '0;
    run_and_check("t1");
    check_eq("t1_iters_k", int'(iter_count), 1);
    check_eq("t1_maxt_k", int'(max_temp), 11);
    check_eq("t1_maxc_k", int'(max_cell), 27);
    rd_cell("t1_c27", 27, 11);
    rd_cell("t1_c26", 26, 0);
    rd_cell("t1_c28", 28, 0);
    rd_cell("t1_c19", 19, 0);
    rd_cell("t1_c35", 35, 0);

    // Zero grid converges on the first sweep
    clear_grid();
    max_iters = 16'd0;
    run_and_check("t2");
    check_eq("t2_conv_k", int'(converged), 1);

    // Uniform Neumann grid stays put
    for (int k = 0; k < N; k++) set_cell(k, 7);
    bnd_neumann = 1'b1; alpha = 3'd7;
    run_and_check("t3");
    rd_cell("t3_c0", 0, 7);
    rd_cell("t3_c63", 63, 7);

    // Abort mid-sweep; a pending write stalls until then
    clear_grid();
    set_cell(27, 15);
    bnd_neumann = 1'b0; alpha = 3'd2; max_iters = 16'd0;
    send(2'b10, 0, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = AW'(0); cmd_data = TW'(9);
    rdy = 0;
    for (int i = 0; i < 28; i++) begin #1; if (cmd_ready) rdy++; @(negedge clk); end
    check_eq("t4_stall", rdy, 0);
    check_eq("t4_busy_mid", int'(busy), 1);
    cmd_op = 2'b11;
    #1;
    check_eq("t4_abort_rdy", int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_eq("t4_busy", int'(busy), 0);
    check_eq("t4_done", int'(done), 0);
    check_eq("t4_iters", int'(iter_count), 0);
    rd_cell("t4_c27", 27, 15);
    rd_cell("t4_c0", 0, 0);
    dump_check("t4");

    // Hot Dirichlet boundary with saturating alpha
    for (int k = 0; k < N; k++) set_cell(k, $urandom_range(15));
    bnd_temp = 4'd15; alpha = 3'd7; max_iters = 16'd3; conv_thresh = '0;
    run_and_check("t5");
    rd_cell("t5_c0", 0, 15);

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < N; k++) set_cell(k, $urandom_range(15));
      alpha       = AL'($urandom_range(7));
      bnd_temp    = TW'($urandom_range(15));
      bnd_neumann = 1'($urandom_range(1));
      conv_thresh = TW'($urandom_range(3));
      max_iters   = 16'($urandom_range(1, 4));
      if ($urandom_range(3) == 0) begin max_iters = 16'd0; alpha = '0; end
      run_and_check($sformatf("rnd%0d", t));
    end

    // Asynchronous reset in the second sweep
    clear_grid();
    set_cell(27, 15);
    bnd_temp = '0; bnd_neumann = 1'b0; alpha = 3'd2; max_iters = 16'd0; conv_thresh = '0;
    send(2'b10, 0, 0);
    repeat (100) @(posedge clk);
    #1;
    check_eq("t6_iters_pre", int'(iter_count), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t6_busy", int'(busy), 0);
    check_eq("t6_done", int'(done), 0);
    check_eq("t6_iters", int'(iter_count), 0);
    check_eq("t6_rdv", int'(rd_valid), 0);
    check_eq("t6_maxt", int'(max_temp), 0);
    check_eq("t6_ready", int'(cmd_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) g[k] = 0;
    #1;
    check_eq("t6_ready_rel", int'(cmd_ready), 1);
    dump_check("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
